// File: rtl/tnet_pkg.sv
// Shared types and beat-field positions for the tnet TX framer.
// Defines the message record, FSM states and the header-beat builder.
package tnet_pkg;

    localparam logic [7:0] TNET_SOF = 8'hC5;

    localparam int BEAT_W      = 64;
    localparam int B0_SOF_LSB  = 56;
    localparam int B0_DST_LSB  = 48;
    localparam int B0_SRC_LSB  = 40;
    localparam int B0_OP_LSB   = 35;
    localparam int B0_SEQ_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } tnet_tx_st_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [7:0]  dst;
        logic [31:0] dt1;
        logic [31:0] dt2;
        logic [31:0] dt3;
    } tnet_msg_t;

    // Header beat: SOF | dst | src | op,3'b0 | seq | 16'h0
    function automatic logic [BEAT_W-1:0] tnet_beat0(
        input logic [7:0]  dst,
        input logic [7:0]  src,
        input logic [4:0]  op,
        input logic [15:0] seq
    );
        logic [BEAT_W-1:0] b;
        b = '0;
        b[B0_SOF_LSB +: 8]  = TNET_SOF;
        b[B0_DST_LSB +: 8]  = dst;
        b[B0_SRC_LSB +: 8]  = src;
        b[B0_OP_LSB  +: 5]  = op;
        b[B0_SEQ_LSB +: 16] = seq;
        return b;
    endfunction

endpackage

// File: rtl/tnet_msg_fifo.sv
// Purpose: first-word-fall-through queue of tnet messages, depth 2**FIFO_AW.
// Latency: a push is visible at the head (empty=0) the cycle after the write.
// Backpressure: full is based on current occupancy; a same-cycle pop does not admit a push.
module tnet_msg_fifo
    import tnet_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  tnet_msg_t push_dat,
    input  logic      pop,
    output tnet_msg_t pop_dat,
    output logic      full,
    output logic      empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    tnet_msg_t            mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(do_pop);
        cnt_d    = cnt_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/tnet_tx_framer.sv
// Purpose: queue tproc messages and emit each as a 3-beat AXI-Stream frame (optional tail XOR: TNET_TX_CHECKSUM_EN).
// Latency: push into empty queue at cycle N -> tvalid at N+2; back-to-back frames without idle beats.
// Backpressure: beats held on !tready; msg_rdy_o drops when the 2**FIFO_AW-entry queue is full.
module tnet_tx_framer
    import tnet_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic        c_clk_i,
    input  logic        c_rst_ni,
    input  logic        channel_up_i,
    input  logic [7:0]  src_id_i,
    input  logic        msg_vld_i,
    output logic        msg_rdy_o,
    input  logic [4:0]  msg_op_i,
    input  logic [7:0]  msg_dst_i,
    input  logic [31:0] msg_dt1_i,
    input  logic [31:0] msg_dt2_i,
    input  logic [31:0] msg_dt3_i,
    output logic [63:0] m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    output logic        m_axis_tlast_o,
    input  logic        m_axis_tready_i,
    output logic [15:0] seq_o,
    output logic [31:0] frame_cnt_o,
    output logic        busy_o
);

    tnet_msg_t   push_msg;
    tnet_msg_t   head_msg;
    logic        fifo_full;
    logic        fifo_empty;
    logic        msg_push;
    logic        fifo_pop;

    tnet_tx_st_t st_q, st_d;
    tnet_msg_t   frm_q, frm_d;
    logic [7:0]  src_q, src_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rdy_en_q, rdy_en_d;

    logic        beat_hs;
    logic        can_start;
    logic [63:0] beat0;
    logic [31:0] tail;

    assign push_msg = '{op:  msg_op_i,
                        dst: msg_dst_i,
                        dt1: msg_dt1_i,
                        dt2: msg_dt2_i,
                        dt3: msg_dt3_i};

    // rdy_en_q keeps msg_rdy_o low while reset is asserted.
    assign msg_rdy_o = rdy_en_q && !fifo_full;
    assign msg_push  = msg_vld_i && msg_rdy_o;

    tnet_msg_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk      (c_clk_i),
        .rst_n    (c_rst_ni),
        .push     (msg_push),
        .push_dat (push_msg),
        .pop      (fifo_pop),
        .pop_dat  (head_msg),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        beat_hs   = (st_q != IDLE) && m_axis_tready_i;
        can_start = !fifo_empty && channel_up_i;
        fifo_pop  = 1'b0;
        rdy_en_d  = 1'b1;
        st_d      = st_q;
        frm_d     = frm_q;
        src_d     = src_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;

        case (st_q)
            IDLE: begin
                if (can_start) begin
                    st_d     = B0;
                    fifo_pop = 1'b1;
                end
            end
            B0: begin
                if (beat_hs) st_d = B1;
            end
            B1: begin
                if (beat_hs) st_d = B2;
            end
            B2: begin
                if (beat_hs) begin
                    seq_d = seq_q + 16'd1;
                    cnt_d = cnt_q + 32'd1;
                    if (can_start) begin
                        st_d     = B0;
                        fifo_pop = 1'b1;
                    end else begin
                        st_d = IDLE;
                    end
                end
            end
            default: st_d = IDLE;
        endcase

        if (fifo_pop) begin
            frm_d = head_msg;
            src_d = src_id_i;
        end
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            st_q     <= IDLE;
            frm_q    <= '0;
            src_q    <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            frm_q    <= frm_d;
            src_q    <= src_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // seq_q only moves on the final beat, so it is the frame's own seq in every beat.
    assign beat0 = tnet_beat0(frm_q.dst, src_q, frm_q.op, seq_q);

`ifdef TNET_TX_CHECKSUM_EN
    assign tail = beat0[63:32] ^ beat0[31:0] ^ frm_q.dt1 ^ frm_q.dt2 ^ frm_q.dt3;
`else
    assign tail = 32'h0000_0000;
`endif

    always_comb begin
        case (st_q)
            B0:      m_axis_tdata_o = beat0;
            B1:      m_axis_tdata_o = {frm_q.dt1, frm_q.dt2};
            B2:      m_axis_tdata_o = {frm_q.dt3, tail};
            default: m_axis_tdata_o = '0;
        endcase
    end

    assign m_axis_tvalid_o = (st_q != IDLE);
    assign m_axis_tlast_o  = (st_q == B2);
    assign seq_o           = seq_q;
    assign frame_cnt_o     = cnt_q;
    assign busy_o          = (st_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tnet_tx_framer.sv
// Scoreboarded bench for tnet_tx_framer: directed latency/backpressure/reset cases plus random traffic.
module tb_tnet_tx_framer;

    logic        clk;
    logic        rst_n;
    logic        channel_up;
    logic [7:0]  src_id;
    logic        msg_vld;
    logic        msg_rdy;
    logic [4:0]  msg_op;
    logic [7:0]  msg_dst;
    logic [31:0] msg_dt1, msg_dt2, msg_dt3;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [15:0] seq;
    logic [31:0] frame_cnt;
    logic        busy;

    int          checks;
    int          errors;
    logic [64:0] exp_q [$];
    logic [15:0] mdl_seq;
    logic [15:0] exp_seq;
    logic [31:0] exp_cnt;
    logic        stall;
    logic [64:0] held;
    bit          rand_done;

    tnet_tx_framer #(.FIFO_AW(2)) dut (
        .c_clk_i         (clk),
        .c_rst_ni        (rst_n),
        .channel_up_i    (channel_up),
        .src_id_i        (src_id),
        .msg_vld_i       (msg_vld),
        .msg_rdy_o       (msg_rdy),
        .msg_op_i        (msg_op),
        .msg_dst_i       (msg_dst),
        .msg_dt1_i       (msg_dt1),
        .msg_dt2_i       (msg_dt2),
        .msg_dt3_i       (msg_dt3),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tlast_o  (tlast),
        .m_axis_tready_i (tready),
        .seq_o           (seq),
        .frame_cnt_o     (frame_cnt),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference: each accepted message becomes three beats, seq assigned in acceptance order.
    task automatic model_frame(input logic [4:0] op, input logic [7:0] dst, input logic [7:0] src,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        logic [63:0] b0;
        logic [31:0] t;
        b0 = {8'hC5, dst, src, op, 3'b000, mdl_seq, 16'h0000};
        t  = 32'h0;
`ifdef TNET_TX_CHECKSUM_EN
        t  = b0[63:32] ^ b0[31:0] ^ d1 ^ d2 ^ d3;
`endif
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, d1, d2});
        exp_q.push_back({1'b1, d3, t});
        mdl_seq = mdl_seq + 16'd1;
    endtask

    task automatic push(input logic [4:0] op, input logic [7:0] dst,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        bit ok;
        ok      = 1'b0;
        msg_vld = 1'b1;
        msg_op  = op;
        msg_dst = dst;
        msg_dt1 = d1;
        msg_dt2 = d2;
        msg_dt3 = d3;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (msg_rdy) begin
                ok = 1'b1;
                model_frame(op, dst, src_id, d1, d2, d3);
            end
            @(posedge clk); #1;
        end
        msg_vld = 1'b0;
        if (!ok) fail_now("push_accept");
    endtask

    task automatic push_rand();
        push(5'($urandom), 8'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tvalid) ok = 1'b1;
        end
        if (!ok) fail_now("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic wait_vld();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (tvalid) ok = 1'b1;
        end
        if (!ok) fail_now("wait_tvalid");
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        mdl_seq = 16'h0;
        exp_seq = 16'h0;
        exp_cnt = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("rst_tvalid", 65'(tvalid), 65'd0);
        check("rst_rdy", 65'(msg_rdy), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_seq", 65'(seq), 65'd0);
        check("rst_cnt", 65'(frame_cnt), 65'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", 65'(msg_rdy), 65'd1);
    endtask

    // Monitor: compares every accepted beat against the scoreboard and polices AXIS stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            check("seq_o", 65'(seq), 65'(exp_seq));
            check("frame_cnt_o", 65'(frame_cnt), 65'(exp_cnt));
            if (stall) begin
                check("hold_tvalid", 65'(tvalid), 65'd1);
                check("hold_beat", {tlast, tdata}, held);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", {tlast, tdata});
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check("beat", {tlast, tdata}, e);
                    if (e[64]) begin
                        exp_seq = exp_seq + 16'd1;
                        exp_cnt = exp_cnt + 32'd1;
                    end
                end
            end
            stall = tvalid && !tready;
            held  = {tlast, tdata};
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        stall      = 1'b0;
        held       = '0;
        rand_done  = 1'b0;
        rst_n      = 1'b0;
        channel_up = 1'b1;
        src_id     = 8'h07;
        msg_vld    = 1'b0;
        msg_op     = '0;
        msg_dst    = '0;
        msg_dt1    = '0;
        msg_dt2    = '0;
        msg_dt3    = '0;
        tready     = 1'b1;
        clear_model();
        do_reset();

        // Single frame, latency and literal header
        msg_vld = 1'b1; msg_op = 5'd3; msg_dst = 8'h12;
        msg_dt1 = 32'd1; msg_dt2 = 32'd2; msg_dt3 = 32'd3;
        @(negedge clk);
        check("t1_rdy", 65'(msg_rdy), 65'd1);
        model_frame(5'd3, 8'h12, 8'h07, 32'd1, 32'd2, 32'd3);
        @(posedge clk); #1;
        msg_vld = 1'b0;
        @(negedge clk);
        check("t1_lat_n1", 65'(tvalid), 65'd0);
        @(negedge clk);
        check("t1_lat_n2", 65'(tvalid), 65'd1);
        check("t1_beat0", 65'(tdata), 65'h0_C512071800000000);
        wait_idle(50);
        check("t1_seq", 65'(seq), 65'd1);
        check("t1_cnt", 65'(frame_cnt), 65'd1);

        // Toggling tready during a frame
        push(5'd9, 8'hA0, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF);
        for (int i = 0; i < 14; i++) begin
            tready = ~tready;
            @(posedge clk); #1;
        end
        tready = 1'b1;
        wait_idle(50);

        // Queue fills to four entries, then 12 back-to-back beats
        do_reset();
        channel_up = 1'b0;
        tready     = 1'b0;
        for (int i = 0; i < 4; i++) push_rand();
        @(negedge clk);
        check("t3_full_rdy", 65'(msg_rdy), 65'd0);
        check("t3_busy", 65'(busy), 65'd1);
        @(posedge clk); #1;
        channel_up = 1'b1;
        tready     = 1'b1;
        @(negedge clk);
        check("t3_start_gap", 65'(tvalid), 65'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t3_b2b_valid", 65'(tvalid), 65'd1);
        end
        @(posedge clk); #1;
        push_rand();
        wait_idle(50);

        // Channel-up gating of frame start only
        channel_up = 1'b0;
        push_rand();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_gated", 65'(tvalid), 65'd0);
        end
        @(posedge clk); #1;
        channel_up = 1'b1;
        @(negedge clk);
        check("t4_start_n1", 65'(tvalid), 65'd0);
        @(negedge clk);
        check("t4_start_n2", 65'(tvalid), 65'd1);
        @(posedge clk); #1;
        channel_up = 1'b0;
        push_rand();
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("t4_second_gated", 65'(tvalid), 65'd0);
        check("t4_busy_queued", 65'(busy), 65'd1);
        @(posedge clk); #1;
        channel_up = 1'b1;
        wait_idle(50);

        // Sequence wrap
        force dut.seq_q = 16'hFFFF;
        exp_seq = 16'hFFFF;
        mdl_seq = 16'hFFFF;
        @(posedge clk); #1;
        release dut.seq_q;
        push_rand();
        wait_idle(50);
        check("t5_seq_wrap", 65'(seq), 65'd0);

        // Random traffic with random tready and channel_up
        src_id = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push_rand();
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                for (int c = 0; c < 4000 && !(rand_done && exp_q.size() == 0); c++) begin
                    tready     = ($urandom_range(0, 3) != 0);
                    channel_up = ($urandom_range(0, 7) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        tready     = 1'b1;
        channel_up = 1'b1;
        wait_idle(200);

        // Asynchronous reset while Beat1 is stalled, with another message queued
        tready = 1'b0;
        push_rand();
        push_rand();
        wait_vld();
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        @(negedge clk);
        check("t6_in_b1", {tvalid, tlast}, 65'b10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("t6_tvalid", 65'(tvalid), 65'd0);
        check("t6_busy", 65'(busy), 65'd0);
        check("t6_seq", 65'(seq), 65'd0);
        check("t6_tlast", 65'(tlast), 65'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        tready = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_flushed", 65'(busy), 65'd0);
        @(posedge clk); #1;
        push_rand();
        wait_idle(50);
        check("t6_seq_restart", 65'(seq), 65'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
